// File: rtl/mul_sign_ctrl_if.sv
// mul_sign_ctrl_if: request, core and response bundle for the multiply control stage
interface mul_sign_ctrl_if #(parameter int TAG_W = 5);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic [31:0]      req_rs1;
    logic [31:0]      req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             core_valid;
    logic [31:0]      core_op1;
    logic [31:0]      core_op2;
    logic             core_kill;
    logic             core_done;
    logic [63:0]      core_prod;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_tag, core_done, core_prod, rsp_ready,
        output req_ready, core_valid, core_op1, core_op2, core_kill, rsp_valid, rsp_data, rsp_tag
    );
    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_tag, core_done, core_prod, rsp_ready,
        input  req_ready, core_valid, core_op1, core_op2, core_kill, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/mul_sign_ctrl.sv
// mul_sign_ctrl: sign handling and sequencing around an unsigned 32x32 multiplier core
module mul_sign_ctrl #(parameter int TAG_W = 5) (
    input logic           clk,
    input logic           rstn,
    input logic           flush,
    mul_sign_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] RESP = 2'd3;
    logic [1:0]       state_q, state_d;
    logic [TAG_W-1:0] tag_q;
    logic             hi_q, neg_q;
    logic [31:0]      mag1_q, mag2_q, result_q;
    logic [63:0]      prod_q;
    logic             accept, zero, hi, s1, s2;
    logic [31:0]      mag1, mag2;
    logic [63:0]      fix_p;
    assign bus.req_ready  = (state_q == IDLE) && !flush;
    assign bus.core_valid = state_q == WAIT;
    assign bus.core_op1   = mag1_q;
    assign bus.core_op2   = mag2_q;
    assign bus.core_kill  = (state_q == WAIT) && flush;
    assign bus.rsp_valid  = state_q == RESP;
    assign bus.rsp_data   = result_q;
    assign bus.rsp_tag    = tag_q;
    // Decode the request: illegal 1xx encodings behave as plain MUL (no signs, low half)
    always_comb begin
        accept = bus.req_valid && bus.req_ready;
        zero   = (bus.req_rs1 == 32'd0) || (bus.req_rs2 == 32'd0);
        hi     = !bus.req_funct3[2] && (bus.req_funct3[1:0] != 2'b00);
        s1     = bus.req_rs1[31] && !bus.req_funct3[2] && (bus.req_funct3[1:0] == 2'b01 || bus.req_funct3[1:0] == 2'b10);
        s2     = bus.req_rs2[31] && (bus.req_funct3 == 3'b001);
        mag1   = s1 ? 32'd0 - bus.req_rs1 : bus.req_rs1;
        mag2   = s2 ? 32'd0 - bus.req_rs2 : bus.req_rs2;
        fix_p  = neg_q ? 64'd0 - prod_q : prod_q;
    end
    // Next state: flush overrides everything and returns to IDLE
    always_comb begin
        state_d = flush ? IDLE :
                  (state_q == IDLE) ? (accept ? (zero ? RESP : WAIT) : IDLE) :
                  (state_q == WAIT) ? (bus.core_done ? FIX : WAIT) :
                  (state_q == FIX)  ? RESP :
                  (bus.rsp_ready ? IDLE : RESP);
    end
    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end
    // Operand, product and result registers; result defaults to 0 for the zero fast path
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_q    <= '0;
            hi_q     <= 1'b0;
            neg_q    <= 1'b0;
            mag1_q   <= '0;
            mag2_q   <= '0;
            prod_q   <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                tag_q    <= bus.req_tag;
                hi_q     <= hi;
                neg_q    <= s1 ^ s2;
                mag1_q   <= mag1;
                mag2_q   <= mag2;
                result_q <= '0;
            end
            if (state_q == WAIT && bus.core_done && !flush) prod_q <= bus.core_prod;
            if (state_q == FIX) result_q <= hi_q ? fix_p[63:32] : fix_p[31:0];
        end
    end
endmodule

// File: tb/tb_mul_sign_ctrl.sv
// tb_mul_sign_ctrl: directed vectors with a response scoreboard for mul_sign_ctrl
module tb_mul_sign_ctrl;
    typedef struct { logic [31:0] d; logic [4:0] t; } rsp_t;
    logic clk, rstn, flush;
    int   total = 0, bad = 0;
    rsp_t sbq[$];
    mul_sign_ctrl_if #(.TAG_W(5)) bus();
    mul_sign_ctrl #(.TAG_W(5)) dut (.clk(clk), .rstn(rstn), .flush(flush), .bus(bus));
    initial clk = 0;
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    // Monitor: every accepted response is matched against the oldest expectation
    always @(negedge clk) begin
        rsp_t e;
        if (rstn && bus.rsp_valid && bus.rsp_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got %h want none", bus.rsp_data);
            end else begin
                e = sbq.pop_front();
                check("rsp_data", bus.rsp_data, e.d);
                check("rsp_tag", bus.rsp_tag, e.t);
            end
        end
    end
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        bus.req_valid = 1; bus.req_funct3 = f3; bus.req_rs1 = a; bus.req_rs2 = b; bus.req_tag = t;
        @(negedge clk);
        check("req_ready_acc", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 0;
    endtask
    task automatic core_step(input logic [31:0] o1, input logic [31:0] o2, input logic [63:0] p,
                             input bit push, input logic [31:0] d, input logic [4:0] t);
        @(negedge clk);
        check("core_valid", bus.core_valid, 1);
        check("core_op1", bus.core_op1, o1);
        check("core_op2", bus.core_op2, o2);
        check("req_ready_busy", bus.req_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("core_op1_hold", bus.core_op1, o1);
        check("core_op2_hold", bus.core_op2, o2);
        bus.core_done = 1; bus.core_prod = p;
        if (push) sbq.push_back('{d, t});
        @(posedge clk); #1;
        bus.core_done = 0; bus.core_prod = 0;
    endtask
    task automatic fix_cycle();
        @(negedge clk);
        check("fix_no_rsp", bus.rsp_valid, 0);
        check("fix_core_valid", bus.core_valid, 0);
        @(posedge clk); #1;
    endtask
    task automatic finish_rsp(input int hold, input logic [31:0] d, input logic [4:0] t);
        bus.rsp_ready = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid", bus.rsp_valid, 1);
            check("bp_data", bus.rsp_data, d);
            check("bp_tag", bus.rsp_tag, t);
            check("bp_req_ready", bus.req_ready, 0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1;
        @(negedge clk);
        check("rsp_valid", bus.rsp_valid, 1);
        check("rsp_core_valid", bus.core_valid, 0);
        check("rsp_req_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("req_ready_after", bus.req_ready, 1);
        check("rsp_valid_after", bus.rsp_valid, 0);
        @(posedge clk); #1;
    endtask
    task automatic op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                      input logic [31:0] o1, input logic [31:0] o2, input logic [63:0] p,
                      input logic [31:0] d, input int hold);
        issue(f3, a, b, t);
        core_step(o1, o2, p, 1, d, t);
        fix_cycle();
        finish_rsp(hold, d, t);
    endtask
    task automatic check_reset_outputs(input string name);
        check({name, "_req_ready"}, bus.req_ready, 1);
        check({name, "_core_valid"}, bus.core_valid, 0);
        check({name, "_core_kill"}, bus.core_kill, 0);
        check({name, "_core_op1"}, bus.core_op1, 0);
        check({name, "_core_op2"}, bus.core_op2, 0);
        check({name, "_rsp_valid"}, bus.rsp_valid, 0);
        check({name, "_rsp_data"}, bus.rsp_data, 0);
        check({name, "_rsp_tag"}, bus.rsp_tag, 0);
    endtask
    initial begin
        rstn = 0; flush = 0;
        bus.req_valid = 0; bus.req_funct3 = 0; bus.req_rs1 = 0; bus.req_rs2 = 0; bus.req_tag = 0;
        bus.core_done = 0; bus.core_prod = 0; bus.rsp_ready = 1;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        @(posedge clk); #1;
        op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd1, 32'd7, 32'hFFFFFFFD, 64'h00000006FFFFFFEB, 32'hFFFFFFEB, 0);
        op(3'b001, 32'h80000000, 32'h80000000, 5'd2, 32'h80000000, 32'h80000000, 64'h4000000000000000, 32'h40000000, 0);
        op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'd1, 32'hFFFFFFFF, 64'h00000000FFFFFFFF, 32'hFFFFFFFF, 0);
        op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32'hFFFFFFFE, 0);
        op(3'b010, 32'h7FFFFFFF, 32'h80000000, 5'd5, 32'h7FFFFFFF, 32'h80000000, 64'h3FFFFFFF80000000, 32'h3FFFFFFF, 0);
        op(3'b100, 32'hFFFFFFFF, 32'd2, 5'd6, 32'hFFFFFFFF, 32'd2, 64'h00000001FFFFFFFE, 32'hFFFFFFFE, 0);
        op(3'b001, 32'hFFFFFFFE, 32'd3, 5'd9, 32'd2, 32'd3, 64'd6, 32'hFFFFFFFF, 5);
        sbq.push_back('{32'd0, 5'd7});
        issue(3'b000, 32'd0, 32'h1234, 5'd7);
        finish_rsp(0, 32'd0, 5'd7);
        sbq.push_back('{32'd0, 5'd8});
        issue(3'b011, 32'hDEADBEEF, 32'd0, 5'd8);
        finish_rsp(2, 32'd0, 5'd8);
        issue(3'b000, 32'd5, 32'd6, 5'd10);
        @(negedge clk);
        check("flw_core_valid", bus.core_valid, 1);
        flush = 1; bus.core_done = 1; bus.core_prod = 64'd30;
        #1;
        check("flw_kill", bus.core_kill, 1);
        check("flw_req_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        flush = 0; bus.core_done = 0; bus.core_prod = 0;
        @(negedge clk);
        check("flw_kill_off", bus.core_kill, 0);
        check("flw_idle", bus.req_ready, 1);
        check("flw_core_valid_off", bus.core_valid, 0);
        check("flw_no_rsp", bus.rsp_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        bus.req_valid = 1; bus.req_funct3 = 3'b000; bus.req_rs1 = 32'd3; bus.req_rs2 = 32'd4; bus.req_tag = 5'd11;
        flush = 1;
        @(negedge clk);
        check("flq_req_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        flush = 0; bus.req_valid = 0;
        @(negedge clk);
        check("flq_no_wait", bus.core_valid, 0);
        check("flq_no_rsp", bus.rsp_valid, 0);
        check("flq_idle", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.rsp_ready = 0;
        issue(3'b000, 32'd0, 32'd5, 5'd12);
        @(negedge clk);
        check("flr_valid", bus.rsp_valid, 1);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk);
        check("flr_drop", bus.rsp_valid, 0);
        check("flr_idle", bus.req_ready, 1);
        bus.rsp_ready = 1;
        @(posedge clk); #1;
        issue(3'b001, 32'hFFFFFFFD, 32'd5, 5'd20);
        core_step(32'd3, 32'd5, 64'd15, 0, 32'd0, 5'd0);
        rstn = 0;
        #1;
        check_reset_outputs("rst_fix");
        @(posedge clk); #1;
        rstn = 1;
        repeat (2) @(negedge clk);
        check("rst_no_rsp", bus.rsp_valid, 0);
        check("rst_idle", bus.req_ready, 1);
        @(posedge clk); #1;
        sbq.push_back('{32'd0, 5'd21});
        issue(3'b010, 32'h1234, 32'd0, 5'd21);
        finish_rsp(0, 32'd0, 5'd21);
        check("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
